// File: rtl/mult_error_sweep_ctrl.sv
// mult_error_sweep_ctrl
//   Drives an exhaustive A/B operand sweep into an external exact multiplier
//   and an external approximate multiplier, then accumulates error statistics
//   from their fed-back products. The statistics are read once o_done is high.
//
//   Optional feature macro: SWEEP_MAXERR_EN. When it is defined, the block
//   tracks the maximum error distance and the first pair that reached it.
//   When it is undefined, o_max_err, o_max_a and o_max_b are tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   i_start               begin a sweep (sampled in IDLE or DONE)
//   i_abort               cancel a sweep (sampled in RUN or DRAIN)
//   o_a, o_b              registered operands to both multipliers
//   i_s_exact, i_s_approx products from the two multipliers for o_a/o_b
//   o_busy, o_done        RUN/DRAIN indicator, DONE level
//   o_err_count           number of pairs with differing products
//   o_err_sum             saturating sum of error distances
//   o_max_err, o_max_a, o_max_b  maximum error distance and its first pair
module mult_error_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_b,
  input  logic [2*WIDTH-1:0] i_s_exact,
  input  logic [2*WIDTH-1:0] i_s_approx,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH:0]   o_err_count,
  output logic [ACC_W-1:0]   o_err_sum,
  output logic [2*WIDTH-1:0] o_max_err,
  output logic [WIDTH-1:0]   o_max_a,
  output logic [WIDTH-1:0]   o_max_b
);

  localparam int PW = 2*WIDTH;
  // Sum is formed one bit wider than the wider of the accumulator and the
  // error distance, so an overflow is always visible before saturating.
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_busy, r_done;
  logic             r_cap_vld;
  logic [PW-1:0]    r_cap_exact, r_cap_approx;
  logic [PW:0]      r_err_count;
  logic [ACC_W-1:0] r_err_sum;

  logic [PW-1:0]    w_ed;
  logic [SW-1:0]    w_sum_ext;
  logic [ACC_W-1:0] w_sum_sat;
  logic             w_last;

  always_comb begin
    w_ed = '0;
    if (r_cap_exact >= r_cap_approx) w_ed = r_cap_exact - r_cap_approx;
    else                             w_ed = r_cap_approx - r_cap_exact;
  end

  assign w_sum_ext = SW'(r_err_sum) + SW'(w_ed);
  assign w_sum_sat = (w_sum_ext > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}}
                                                       : w_sum_ext[ACC_W-1:0];
  assign w_last    = (&r_a) & (&r_b);

`ifdef SWEEP_MAXERR_EN
  logic [WIDTH-1:0] r_cap_a, r_cap_b;
  logic [PW-1:0]    r_max_err;
  logic [WIDTH-1:0] r_max_a, r_max_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cap_vld    <= 1'b0;
      r_cap_exact  <= '0;
      r_cap_approx <= '0;
      r_err_count  <= '0;
      r_err_sum    <= '0;
`ifdef SWEEP_MAXERR_EN
      r_cap_a      <= '0;
      r_cap_b      <= '0;
      r_max_err    <= '0;
      r_max_a      <= '0;
      r_max_b      <= '0;
`endif
    end else begin
      // Accumulate whatever the capture stage held, in any state; an abort
      // only drops the pair being captured on the abort edge.
      if (r_cap_vld) begin
        if (w_ed != '0) r_err_count <= r_err_count + (PW+1)'(1);
        r_err_sum <= w_sum_sat;
`ifdef SWEEP_MAXERR_EN
        // Strictly greater keeps the first pair in sweep order.
        if (w_ed > r_max_err) begin
          r_max_err <= w_ed;
          r_max_a   <= r_cap_a;
          r_max_b   <= r_cap_b;
        end
`endif
      end
      r_cap_vld <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_cap_exact  <= '0;
            r_cap_approx <= '0;
            r_err_count  <= '0;
            r_err_sum    <= '0;
`ifdef SWEEP_MAXERR_EN
            r_cap_a      <= '0;
            r_cap_b      <= '0;
            r_max_err    <= '0;
            r_max_a      <= '0;
            r_max_b      <= '0;
`endif
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cap_vld    <= 1'b1;
            r_cap_exact  <= i_s_exact;
            r_cap_approx <= i_s_approx;
`ifdef SWEEP_MAXERR_EN
            r_cap_a      <= r_a;
            r_cap_b      <= r_b;
`endif
            // The last pair stays on A/B through DRAIN and DONE.
            if (w_last) r_state <= S_DRAIN;
            else        {r_b, r_a} <= {r_b, r_a} + PW'(1);
          end
        end
        S_DRAIN: begin
          r_busy <= 1'b0;
          if (i_abort) r_state <= S_IDLE;
          else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err_count = r_err_count;
  assign o_err_sum   = r_err_sum;

`ifdef SWEEP_MAXERR_EN
  assign o_max_err = r_max_err;
  assign o_max_a   = r_max_a;
  assign o_max_b   = r_max_b;
`else
  assign o_max_err = '0;
  assign o_max_a   = '0;
  assign o_max_b   = '0;
`endif

endmodule

// File: tb/tb_mult_error_sweep_ctrl.sv
module tb_mult_error_sweep_ctrl;

`ifdef SWEEP_MAXERR_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // WIDTH=8 instance, ACC_W=32
  logic        st8 = 0, ab8 = 0;
  logic [7:0]  a8, b8, maxa8, maxb8;
  logic [15:0] ex8, ap8, maxe8;
  logic        busy8, done8;
  logic [16:0] cnt8;
  logic [31:0] sum8;
  int          mode8 = 0;

  // WIDTH=4 instance, ACC_W=14 (small so saturation is reachable)
  logic        st4 = 0, ab4 = 0;
  logic [3:0]  a4, b4, maxa4, maxb4;
  logic [7:0]  ex4, ap4, maxe4;
  logic        busy4, done4;
  logic [8:0]  cnt4;
  logic [13:0] sum4;
  int          mode4 = 0;

  // Multiplier models: 0 exact, 1 LSB forced 0, 2 MSB flipped
  always_comb begin
    ex8 = 16'(a8) * 16'(b8);
    ap8 = ex8;
    if (mode8 == 1) ap8 = {ex8[15:1], 1'b0};
    else if (mode8 == 2) ap8 = ex8 ^ 16'h8000;
    ex4 = 8'(a4) * 8'(b4);
    ap4 = ex4;
    if (mode4 == 1) ap4 = {ex4[7:1], 1'b0};
    else if (mode4 == 2) ap4 = ex4 ^ 8'h80;
  end

  mult_error_sweep_ctrl #(.WIDTH(8), .ACC_W(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(st8), .i_abort(ab8),
    .o_a(a8), .o_b(b8), .i_s_exact(ex8), .i_s_approx(ap8),
    .o_busy(busy8), .o_done(done8), .o_err_count(cnt8), .o_err_sum(sum8),
    .o_max_err(maxe8), .o_max_a(maxa8), .o_max_b(maxb8));

  mult_error_sweep_ctrl #(.WIDTH(4), .ACC_W(14)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(st4), .i_abort(ab4),
    .o_a(a4), .o_b(b4), .i_s_exact(ex4), .i_s_approx(ap4),
    .o_busy(busy4), .o_done(done4), .o_err_count(cnt4), .o_err_sum(sum4),
    .o_max_err(maxe4), .o_max_a(maxa4), .o_max_b(maxb4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves time at #1 after edge 0 (the edge sampling start).
  task automatic go4();
    @(negedge clk); st4 = 1'b1;
    @(posedge clk); #1; st4 = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns the edge number after which done was first seen high.
  task automatic wait_done4(output int k);
    k = 0;
    while (done4 !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
  endtask

  task automatic chk4_all_zero(input string tag);
    chk({tag, "_a4"}, a4, 0);       chk({tag, "_b4"}, b4, 0);
    chk({tag, "_busy4"}, busy4, 0); chk({tag, "_done4"}, done4, 0);
    chk({tag, "_cnt4"}, cnt4, 0);   chk({tag, "_sum4"}, sum4, 0);
    chk({tag, "_max4"}, {maxe4, maxa4, maxb4}, 0);
  endtask

  initial begin
    int k, ovl;

    // Reset state, observed before any clock edge
    #2;
    chk4_all_zero("rst");
    chk("rst_a8b8", {a8, b8}, 0);
    chk("rst_flags8", {busy8, done8}, 0);
    chk("rst_stats8", {cnt8, sum8, maxe8}, 0);
    step(2);
    @(negedge clk); rst_n = 1'b1;
    step(2);
    chk("idle_abort_ignored_busy4", busy4, 0);

    // WIDTH=8, LSB-forced model: odd*odd pairs differ by 1 -> 128*128
    mode8 = 1;
    @(negedge clk); st8 = 1'b1;
    @(posedge clk); #1; st8 = 1'b0;
    chk("w8_busy_after_edge0", busy8, 1);
    k = 0; ovl = 0;
    while (done8 !== 1'b1 && k < 70000) begin
      @(posedge clk); #1; k++;
      if (busy8 && done8) ovl++;
    end
    chk("w8_done_edge", k, 65537);
    chk("w8_busy_done_overlap", ovl, 0);
    chk("w8_busy_in_done", busy8, 0);
    chk("w8_err_count", cnt8, 16384);
    chk("w8_err_sum", sum8, 16384);
    chk("w8_max_err", maxe8, MAXEN ? 1 : 0);
    chk("w8_max_a", maxa8, MAXEN ? 1 : 0);
    chk("w8_max_b", maxb8, MAXEN ? 1 : 0);
    chk("w8_a_final", a8, 255);
    chk("w8_b_final", b8, 255);

    // WIDTH=4, exact model: full operand sequence and done timing
    mode4 = 0;
    go4();
    chk("w4_seq_p0", {b4, a4}, 0);
    for (int p = 1; p < 256; p++) begin
      step(1);
      chk("w4_seq", {b4, a4}, {p[7:4], p[3:0]});
    end
    step(1);
    chk("w4_edge256_busy", busy4, 1);
    chk("w4_edge256_done", done4, 0);
    chk("w4_edge256_ab", {b4, a4}, 8'hff);
    step(1);
    chk("w4_edge257_done", done4, 1);
    chk("w4_edge257_busy", busy4, 0);
    chk("w4_exact_stats", {cnt4, sum4, maxe4}, 0);
    chk("w4_exact_ab", {b4, a4}, 8'hff);
    step(3);
    chk("w4_done_level", done4, 1);

    // WIDTH=4, MSB flip: every pair errs by 128; sum saturates at 2^14-1
    mode4 = 2;
    go4();
    chk("w4_restart_done_low", done4, 0);
    wait_done4(k);
    chk("w4_xor_done_edge", k, 257);
    chk("w4_xor_count", cnt4, 256);
    chk("w4_xor_sum_sat", sum4, 16383);
    chk("w4_xor_max_err", maxe4, MAXEN ? 128 : 0);
    chk("w4_xor_max_ab", {maxa4, maxb4}, 0);

    // Abort sampled at edge 100 together with start: pairs 0..98 counted
    // (odd*odd pairs up to index 98: rows B=1,3,5 x 8 odd A = 24)
    mode4 = 1;
    go4();
    step(99);
    ab4 = 1'b1; st4 = 1'b1;
    step(1);
    ab4 = 1'b0; st4 = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_count", cnt4, 24);
    chk("abort_sum", sum4, 24);
    chk("abort_max_err", maxe4, MAXEN ? 1 : 0);
    chk("abort_max_ab", {maxa4, maxb4}, MAXEN ? 8'h11 : 8'h00);
    step(1);
    chk("abort_start_ignored_busy", busy4, 0);
    chk("abort_hold_count", cnt4, 24);
    step(20);
    chk("abort_idle_done", done4, 0);

    // Asynchronous reset mid-sweep, then a clean full sweep
    go4();
    step(100);
    #2; rst_n = 1'b0;
    #1;
    chk4_all_zero("async_rst");
    chk("async_rst_a8b8", {a8, b8}, 0);
    chk("async_rst_flags8", {busy8, done8}, 0);
    chk("async_rst_stats8", {cnt8, sum8, maxe8, maxa8, maxb8}, 0);
    @(negedge clk); rst_n = 1'b1;
    go4();
    wait_done4(k);
    chk("post_rst_done_edge", k, 257);
    chk("post_rst_count", cnt4, 64);
    chk("post_rst_sum", sum4, 64);
    chk("post_rst_max_err", maxe4, MAXEN ? 1 : 0);
    chk("post_rst_max_ab", {maxa4, maxb4}, MAXEN ? 8'h11 : 8'h00);
    chk("post_rst_ab", {b4, a4}, 8'hff);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
